vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
Display-side consumer of the 1-bit 640x480 frame buffer. Generates VGA 640x480@60 timing, issues the linear read address to the frame buffer's synchronous read port, and aligns the returned 1-bit pixel with delayed sync and blank signals. Maps each bit to a foreground or background RGB colour and drives the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
ADDR_W, 19, frame buffer address width
COLOR_W, 4, bits per colour channel

Ports:
clk  in  1  system clock
rst  in  1  reset
pix_en  in  1  pixel-rate strobe, one clk wide
fg_color  in  3*COLOR_W  {R,G,B} colour for bit=1
bg_color  in  3*COLOR_W  {R,G,B} colour for bit=0
fb_rd_data  in  1  frame buffer read data (1 clk read latency)
fb_addr  out  ADDR_W  frame buffer read address
red  out  COLOR_W  VGA red
green  out  COLOR_W  VGA green
blue  out  COLOR_W  VGA blue
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
vblank  out  1  high while output stage is outside visible lines
frame_start  out  1  one-clk pulse when counters enter (0,0)
test_mode  in  1  present only with VGA_TEST_PATTERN_EN

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. All state is updated on the clk rising edge and only when pix_en=1, except frame_start, which is a one-clk pulse.
- Reset values:
  - h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, where H_TOTAL=800 and V_TOTAL=525. The first pix_en after reset therefore enters (0,0).
  - fb_addr=0, red/green/blue=0, hsync=1, vsync=1, vblank=1, frame_start=0.
- pix_en must have at least one idle clk between pulses. Intended use is 100 MHz clk with pix_en every 4th clk.
- Stage 0 (tick n): counters advance to position P.
  - h_cnt wraps at H_TOTAL-1 to 0 and increments v_cnt.
  - v_cnt wraps at V_TOTAL-1 to 0.
  - fb_addr is registered as v_cnt*H_ACTIVE+h_cnt whenever P is active (h<H_ACTIVE, v<V_ACTIVE). Implement it as a running counter, with no multiplier.
  - fb_addr is set to 0 when P=(0,0), increments by 1 on each subsequent active P, and holds its value during blanking.
  - Its maximum value is 307199.
- Stage 1 (tick n+1): fb_rd_data is now bram[addr(P)]. Registered outputs for P:
  - active: RGB = fb_rd_data ? fg_color : bg_color; otherwise RGB=0.
  - hsync=0 iff h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751].
  - vsync=0 iff v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491].
  - vblank=1 iff v>=V_ACTIVE.
  - Sync, blank and colour are delayed together, so latency from counter position to pins is exactly 1 pix_en tick.
- fg_color and bg_color are sampled at stage 1. Changing them mid-line takes effect on the next output pixel.
- frame_start goes high for exactly one clk: the clk after the pix_en edge on which counters enter (0,0). It pulses once per 420000 ticks.
- pix_en low: all outputs and counters hold; frame_start stays 0.
- rst mid-frame: outputs go to reset values immediately (asynchronously). After release, the first pix_en starts a clean frame at (0,0) with a frame_start pulse.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined: adds input test_mode. When test_mode=1, the stage-1 pixel bit is h[3]^v[3] (8x8 checkerboard) instead of fb_rd_data.
  - fb_addr generation, sync and colour mapping are unchanged.
  - test_mode is sampled at stage 1.
- Not defined: no test_mode port; the pixel bit is always fb_rd_data.

Test Plan:
- Reset, then pix_en every 4 clk, 2 frames -> hsync low 96 ticks every 800, first low at output of h=656; vsync low 2 lines every 525; vblank high lines 480-524.
- Frame buffer model with bram[0]=1, bram[1]=0, bram[640]=1, fg=12'hFFF, bg=12'h00F -> first output pixel FFF, second 00F, line 1 pixel 0 FFF; each appears 1 tick after its counter position.
- Monitor fb_addr -> 0 at (0,0), 639 at (639,0), 640 at (0,1), 307199 at (639,479), held through blanking, 0 at next frame.
- Count frame_start -> exactly one 1-clk pulse per 420000 pix_en ticks, the first one right after reset release.
- Assert rst at (300,200) for 3 clk -> same clk: rgb=0, hsync=vsync=1, fb_addr=0; after release, first tick gives frame_start and fb_addr=0.
- With VGA_TEST_PATTERN_EN and test_mode=1, fb_rd_data tied 0 -> pixels (0..7,0)=bg, (8..15,0)=fg, (0,8)=fg; fb_addr sequence unchanged.

Source files
------------

// File: rtl/vga_scanout.sv
// ============================================================================
// Module   : vga_scanout
// Brief    : 640x480@60 VGA timing and 1-bit frame-buffer scan-out with
//            colour mapping. Optional macro VGA_TEST_PATTERN_EN adds a
//            test_mode input that substitutes an 8x8 checkerboard for fb data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19,
  parameter int COLOR_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_en,
  input  logic [3*COLOR_W-1:0]   fg_color,
  input  logic [3*COLOR_W-1:0]   bg_color,
  input  logic                   fb_rd_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                   test_mode,
`endif
  output logic [ADDR_W-1:0]      fb_addr,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   vblank,
  output logic                   frame_start
);

  localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int C_HW      = $clog2(C_H_TOTAL);
  localparam int C_VW      = $clog2(C_V_TOTAL);

  localparam logic [C_HW-1:0]   C_H_LAST   = C_HW'(C_H_TOTAL - 1);
  localparam logic [C_VW-1:0]   C_V_LAST   = C_VW'(C_V_TOTAL - 1);
  localparam logic [C_HW-1:0]   C_H_ACT    = C_HW'(H_ACTIVE);
  localparam logic [C_VW-1:0]   C_V_ACT    = C_VW'(V_ACTIVE);
  localparam logic [C_HW-1:0]   C_HS_BEG   = C_HW'(H_ACTIVE + H_FP);
  localparam logic [C_HW-1:0]   C_HS_END   = C_HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [C_VW-1:0]   C_VS_BEG   = C_VW'(V_ACTIVE + V_FP);
  localparam logic [C_VW-1:0]   C_VS_END   = C_VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [C_HW-1:0]   C_H_ONE    = C_HW'(1);
  localparam logic [C_VW-1:0]   C_V_ONE    = C_VW'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);

  logic [C_HW-1:0]        r_h_cnt;
  logic [C_VW-1:0]        r_v_cnt;
  logic [C_HW-1:0]        w_h_nxt;
  logic [C_VW-1:0]        w_v_nxt;
  logic                   w_nxt_active;
  logic                   w_nxt_origin;
  logic                   w_cur_active;
  logic                   w_pix_bit;
  logic [3*COLOR_W-1:0]   w_rgb;

  always_comb begin
    w_h_nxt = r_h_cnt + C_H_ONE;
    w_v_nxt = r_v_cnt;
    if (r_h_cnt == C_H_LAST) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + C_V_ONE;
    end
  end

  assign w_nxt_active = (w_h_nxt < C_H_ACT) && (w_v_nxt < C_V_ACT);
  assign w_nxt_origin = (w_h_nxt == '0) && (w_v_nxt == '0);
  // The current counters are the position whose fb data is now on fb_rd_data.
  assign w_cur_active = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);

`ifdef VGA_TEST_PATTERN_EN
  assign w_pix_bit = test_mode ? (r_h_cnt[3] ^ r_v_cnt[3]) : fb_rd_data;
`else
  assign w_pix_bit = fb_rd_data;
`endif

  assign w_rgb = w_cur_active ? (w_pix_bit ? fg_color : bg_color) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt     <= C_H_LAST;
      r_v_cnt     <= C_V_LAST;
      fb_addr     <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vblank      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        r_h_cnt     <= w_h_nxt;
        r_v_cnt     <= w_v_nxt;
        frame_start <= w_nxt_origin;
        // Running address: restart at the origin, hold through blanking.
        if (w_nxt_active) begin
          fb_addr <= w_nxt_origin ? '0 : fb_addr + C_ADDR_ONE;
        end
        {red, green, blue} <= w_rgb;
        hsync  <= !((r_h_cnt >= C_HS_BEG) && (r_h_cnt <= C_HS_END));
        vsync  <= !((r_v_cnt >= C_VS_BEG) && (r_v_cnt <= C_VS_END));
        vblank <= (r_v_cnt >= C_V_ACT);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_scanout.sv
// ============================================================================
// Module   : tb_vga_scanout
// Brief    : Scoreboard bench for vga_scanout on reduced timing (48x27 totals,
//            32x20 active); define VGA_TEST_PATTERN_EN for the checker phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_scanout;

  localparam int HA = 32, HF = 4, HS = 8, HB = 4;
  localparam int VA = 20, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int AW = 10;
  localparam int CW = 4;

  typedef struct packed {
    logic [11:0]   rgb;
    logic          hs;
    logic          vs;
    logic          vb;
    logic          fs;
    logic [AW-1:0] addr;
  } exp_t;

  localparam exp_t RST_EXP = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, vb: 1'b1,
                               fs: 1'b0, addr: '0};

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_en = 1'b0;
  logic [11:0]   fg_color = 12'hFFF;
  logic [11:0]   bg_color = 12'h00F;
  logic          fb_rd_data = 1'b0;
  logic          test_mode = 1'b0;
  logic [AW-1:0] fb_addr;
  logic [CW-1:0] red, green, blue;
  logic          hsync, vsync, vblank, frame_start;

  logic bram [0:HA*VA-1];

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   mh, mv, maddr;
  int   exp_frames = 0;
  int   seen_frames = 0;
  exp_t last = RST_EXP;
  exp_t mon_e;
  logic seen_tick, seen_rst;

  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ADDR_W(AW), .COLOR_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_en(pix_en),
    .fg_color(fg_color),
    .bg_color(bg_color),
    .fb_rd_data(fb_rd_data),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .fb_addr(fb_addr),
    .red(red),
    .green(green),
    .blue(blue),
    .hsync(hsync),
    .vsync(vsync),
    .vblank(vblank),
    .frame_start(frame_start)
  );

  // Frame buffer with one clk read latency.
  always @(posedge clk) fb_rd_data <= bram[fb_addr];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e);
    chk({nm, "_rgb"},   int'({red, green, blue}), int'(e.rgb));
    chk({nm, "_hsync"}, int'(hsync),       int'(e.hs));
    chk({nm, "_vsync"}, int'(vsync),       int'(e.vs));
    chk({nm, "_vblank"},int'(vblank),      int'(e.vb));
    chk({nm, "_fstart"},int'(frame_start), int'(e.fs));
    chk({nm, "_addr"},  int'(fb_addr),     int'(e.addr));
  endtask

  // Monitor: every clk, a tick pops the next expected response; otherwise
  // the outputs must hold their last value with frame_start low.
  always begin
    @(posedge clk);
    seen_tick = pix_en;
    seen_rst  = rst;
    #1;
    if (seen_rst || rst) begin
      last = RST_EXP;
    end else if (seen_tick) begin
      if (frame_start) seen_frames++;
      if (q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        mon_e = q.pop_front();
        cmp("tick", mon_e);
        last    = mon_e;
        last.fs = 1'b0;
      end
    end else begin
      cmp("hold", last);
    end
  end

  // One pix_en tick: model the output for the current position and the
  // counter/address state for the next one, then strobe.
  task automatic tick();
    exp_t e;
    int   nh, nv;
    logic act, b;
    @(negedge clk);
    act = (mh < HA) && (mv < VA);
    b   = 1'b0;
    if (act) b = test_mode ? (mh[3] ^ mv[3]) : bram[mv*HA + mh];
    e.rgb = act ? (b ? fg_color : bg_color) : 12'h000;
    e.hs  = !((mh >= HA + HF) && (mh < HA + HF + HS));
    e.vs  = !((mv >= VA + VF) && (mv < VA + VF + VS));
    e.vb  = (mv >= VA);
    nh = (mh == HT - 1) ? 0 : mh + 1;
    nv = (mh == HT - 1) ? ((mv == VT - 1) ? 0 : mv + 1) : mv;
    if (nh < HA && nv < VA) maddr = nv*HA + nh;
    e.addr = AW'(maddr);
    e.fs   = (nh == 0) && (nv == 0);
    if (e.fs) exp_frames++;
    mh = nh;
    mv = nv;
    q.push_back(e);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_rgb",    int'({red, green, blue}), 0);
    chk("rst_hsync",  int'(hsync),  1);
    chk("rst_vsync",  int'(vsync),  1);
    chk("rst_vblank", int'(vblank), 1);
    chk("rst_addr",   int'(fb_addr), 0);
    chk("rst_fstart", int'(frame_start), 0);
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    mh    = HT - 1;
    mv    = VT - 1;
    maddr = 0;
  endtask

  initial begin
    for (int a = 0; a < HA*VA; a++) bram[a] = ((a % 3) == 0);
    bram[0]  = 1'b1;
    bram[1]  = 1'b0;
    bram[HA] = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;

    do_reset();
    // Two full frames plus a few ticks, with colour changes in frame two.
    for (int i = 0; i < 2*HT*VT + 5; i++) begin
      if (i == HT*VT + 100) fg_color = 12'hA50;
      if (i == HT*VT + 400) bg_color = 12'h3C0;
      tick();
    end

    // Reset in the middle of active video.
    for (int i = 0; i < HT*VT && !(mh == 20 && mv == 10); i++) tick();
    chk("pos_reached", mh*1000 + mv, 20*1000 + 10);
    do_reset();
    fg_color = 12'hFFF;
    bg_color = 12'h00F;
    for (int i = 0; i < 30; i++) tick();

`ifdef VGA_TEST_PATTERN_EN
    do_reset();
    test_mode = 1'b1;
    for (int i = 0; i < 9*HT + 20; i++) tick();
    test_mode = 1'b0;
`endif

    repeat (4) @(negedge clk);
    chk("frame_count", seen_frames, exp_frames);
    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
